busmatrix_arbiter: RTL and testbench

- Per-slave-port AHB arbiter in the busmatrix.
- Produces the one-hot address-phase and data-phase select vectors that drive the configurable select muxes:
  - address-phase mux: transaction attributes;
  - data-phase mux: HWDATA and responses.
- Arbitration is round-robin among requesting slave interfaces. The grant is held for fixed-length bursts, open INCR bursts and locked sequences.
- One instance per slave port; it sits between the slave-interface request lines and the mux select inputs.

---
 rtl/busmatrix_pkg.sv | 46 ++++
 rtl/busmatrix_arbiter_if.sv | 28 ++
 rtl/busmatrix_rr_pick.sv | 38 +++
 rtl/busmatrix_arbiter.sv | 119 +++++++++++
 tb/tb_busmatrix_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/busmatrix_pkg.sv
// Shared definitions for the AHB busmatrix arbiters.
//   - HTRANS / HBURST encodings
//   - burst_beats(): number of beats implied by an HBURST value
//   - onehot_to_idx(): binary index of a one-hot (or zero) select vector
package busmatrix_pkg;

    localparam int unsigned MAX_PORTS = 16;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Open INCR reports a single beat; its length is tracked by the request line instead.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd1;
        endcase
        return beats;
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_PORTS-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_PORTS); i++) begin
            if (onehot[i]) begin
                idx |= 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/busmatrix_arbiter_if.sv
// Request/select bundle between the slave interfaces and one slave-port arbiter.
//   master modport : request side (req, lock, selected HTRANS/HBURST, HREADYOUT)
//   slave modport  : arbiter side (addr_sel, data_sel, hmaster, hmastlock)
interface busmatrix_arbiter_if #(
    parameter int unsigned NUM_PORTS = 16
);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] lock;
    logic [1:0]           htrans;
    logic [2:0]           hburst;
    logic                 hready;
    logic [NUM_PORTS-1:0] addr_sel;
    logic [NUM_PORTS-1:0] data_sel;
    logic [3:0]           hmaster;
    logic                 hmastlock;

    modport master (
        output req, lock, htrans, hburst, hready,
        input  addr_sel, data_sel, hmaster, hmastlock
    );

    modport slave (
        input  req, lock, htrans, hburst, hready,
        output addr_sel, data_sel, hmaster, hmastlock
    );

endinterface

// File: rtl/busmatrix_rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector
//   i_ptr    : index of the last winner; search starts at i_ptr+1 and wraps
//   o_winner : one-hot winner (zero when no request)
//   o_idx    : binary index of the winner
//   o_valid  : at least one request present
// The port at i_ptr is examined last, so a previous winner only wins again when
// nobody else is asking.
module busmatrix_rr_pick #(
    parameter int unsigned NUM_PORTS = 16,
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_winner,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            // NUM_PORTS is a power of two, so masking gives the wrap-around.
            w_idx = (i_ptr + IDX_W'(i)) & IDX_W'(NUM_PORTS - 1);
            if (!o_valid && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                o_idx           = w_idx;
                o_valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/busmatrix_arbiter.sv
// Per-slave-port AHB arbiter.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   io_bus        : req/lock/htrans/hburst/hready in; addr_sel/data_sel (one-hot or zero),
//                   hmaster (owner index) and hmastlock out
// Grants round-robin on accepted address phases and keeps the grant for fixed-length
// bursts, open INCR bursts (while the owner keeps requesting) and locked sequences.
module busmatrix_arbiter
    import busmatrix_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 16
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    busmatrix_arbiter_if.slave  io_bus
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] r_addr_sel;
    logic [NUM_PORTS-1:0] r_data_sel;
    logic [3:0]           r_cnt;
    logic                 r_incr;
    logic [IDX_W-1:0]     r_ptr;

    logic [NUM_PORTS-1:0] w_addr_nxt;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [3:0]           w_cnt_nxt;
    logic                 w_incr_nxt;
    logic [4:0]           w_beats;
    logic                 w_owner_req;
    logic                 w_owner_lock;
    logic                 w_hold;
    logic [NUM_PORTS-1:0] w_pick;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;

    // Selects are one-hot, so masking and OR-reducing picks out the owner's bit.
    assign w_owner_req  = |(io_bus.req & r_addr_sel);
    assign w_owner_lock = |(io_bus.lock & r_addr_sel);
    assign w_beats      = burst_beats(io_bus.hburst);

    busmatrix_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .i_req    (io_bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_pick),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_incr_nxt = r_incr;
        case (io_bus.htrans)
            HTRANS_NONSEQ: begin
                w_cnt_nxt  = 4'(w_beats - 5'd1);
                w_incr_nxt = (io_bus.hburst == HBURST_INCR);
            end
            HTRANS_SEQ: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            HTRANS_IDLE: begin
                w_cnt_nxt  = 4'd0;
                w_incr_nxt = 1'b0;
            end
            default: ;  // BUSY leaves burst state alone
        endcase

        // The open-INCR term uses the updated flag so the NONSEQ that opens an
        // INCR burst already holds the grant.
        w_hold = w_owner_lock
               | (io_bus.htrans == HTRANS_BUSY)
               | (w_incr_nxt & w_owner_req)
               | ((io_bus.htrans == HTRANS_NONSEQ) && (w_beats > 5'd1))
               | ((io_bus.htrans == HTRANS_SEQ) && (r_cnt > 4'd1));

        w_addr_nxt = r_addr_sel;
        w_ptr_nxt  = r_ptr;
        if (!w_hold) begin
            if (w_pick_valid) begin
                w_addr_nxt = w_pick;
                w_ptr_nxt  = w_pick_idx;
            end else begin
                w_addr_nxt = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr_sel <= '0;
            r_data_sel <= '0;
            r_cnt      <= 4'd0;
            r_incr     <= 1'b0;
            r_ptr      <= IDX_W'(NUM_PORTS - 1);
        end else if (io_bus.hready) begin
            r_addr_sel <= w_addr_nxt;
            r_data_sel <= r_addr_sel;
            r_cnt      <= w_cnt_nxt;
            r_incr     <= w_incr_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    assign io_bus.addr_sel  = r_addr_sel;
    assign io_bus.data_sel  = r_data_sel;
    assign io_bus.hmaster   = onehot_to_idx(MAX_PORTS'(r_addr_sel));
    assign io_bus.hmastlock = w_owner_lock;

    // An owner must keep requesting until its fixed-length burst has completed.
    a_no_early_withdraw: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(io_bus.hready && (|r_addr_sel) && !w_owner_req &&
          (((io_bus.htrans == HTRANS_NONSEQ) && (w_beats > 5'd1)) ||
           ((io_bus.htrans == HTRANS_SEQ) && (r_cnt > 4'd1)))));

endmodule

// File: tb/tb_busmatrix_arbiter.sv
// Directed, table-driven bench for busmatrix_arbiter (16 ports).
module tb_busmatrix_arbiter;
    import busmatrix_pkg::*;

    localparam int unsigned N = 16;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    busmatrix_arbiter_if #(.NUM_PORTS(N)) bus_if ();

    busmatrix_arbiter #(
        .NUM_PORTS (N)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .io_bus  (bus_if)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [15:0] req;
        logic [15:0] lock;
        logic [1:0]  htrans;
        logic [2:0]  hburst;
        logic        hready;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        logic [3:0]  exp_hm;
        logic        exp_lk;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input string nm, input logic [15:0] rq, input logic [15:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic [15:0] ea, input logic [15:0] ed, input logic [3:0] eh,
                       input logic el);
        vec_t v;
        v.name = nm; v.req = rq; v.lock = lk; v.htrans = tr; v.hburst = bu; v.hready = rdy;
        v.exp_addr = ea; v.exp_data = ed; v.exp_hm = eh; v.exp_lk = el;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [15:0] ea, input logic [15:0] ed,
                             input logic [3:0] eh, input logic el);
        check({nm, ".addr_sel"}, bus_if.addr_sel, ea);
        check({nm, ".data_sel"}, bus_if.data_sel, ed);
        check({nm, ".hmaster"}, 16'(bus_if.hmaster), 16'(eh));
        check({nm, ".hmastlock"}, 16'(bus_if.hmastlock), 16'(el));
    endtask

    task automatic drive(input logic [15:0] rq, input logic [15:0] lk, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        bus_if.req    = rq;
        bus_if.lock   = lk;
        bus_if.htrans = tr;
        bus_if.hburst = bu;
        bus_if.hready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Round-robin from reset, then a fixed INCR4 on port 2.
        add("rr_first",    16'h0005, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0001, 16'h0000, 4'd0, 1'b0);
        add("rr_next",     16'h0005, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0004, 16'h0001, 4'd2, 1'b0);
        add("incr4_ns",    16'h0006, 16'h0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("incr4_s1",    16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("incr4_s2",    16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("incr4_s3",    16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 16'h0002, 16'h0004, 4'd1, 1'b0);
        // hready low freezes both selects even when a new grant would be due.
        add("frz_idle",    16'h0004, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 16'h0002, 16'h0004, 4'd1, 1'b0);
        add("regrant_p2",  16'h0004, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0004, 16'h0002, 4'd2, 1'b0);
        // INCR4 with wait states on beat 2; req/lock changes during the wait are ignored.
        add("wait_ns",     16'h0006, 16'h0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("wait_frz0",   16'h0002, 16'h0008, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("wait_frz1",   16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("wait_frz2",   16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("wait_s1",     16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("wait_s2",     16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 16'h0004, 16'h0004, 4'd2, 1'b0);
        add("wait_s3",     16'h0006, 16'h0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 16'h0002, 16'h0004, 4'd1, 1'b0);
        // Locked owner keeps the grant after dropping req.
        add("lock_grant",  16'h0008, 16'h0008, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0008, 16'h0002, 4'd3, 1'b1);
        add("lock_ns",     16'hFFF7, 16'h0008, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1);
        add("lock_idle",   16'hFFF7, 16'h0008, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1);
        add("lock_drop",   16'hFFF7, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0010, 16'h0008, 4'd4, 1'b0);
        // Open INCR on port 0 with a BUSY beat.
        add("oi_grant",    16'h0001, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0001, 16'h0010, 4'd0, 1'b0);
        add("oi_ns",       16'hFFFF, 16'h0000, HTRANS_NONSEQ, HBURST_INCR,   1'b1, 16'h0001, 16'h0001, 4'd0, 1'b0);
        add("oi_s1",       16'hFFFF, 16'h0000, HTRANS_SEQ,    HBURST_INCR,   1'b1, 16'h0001, 16'h0001, 4'd0, 1'b0);
        add("oi_busy",     16'hFFFF, 16'h0000, HTRANS_BUSY,   HBURST_INCR,   1'b1, 16'h0001, 16'h0001, 4'd0, 1'b0);
        add("oi_s2",       16'hFFFF, 16'h0000, HTRANS_SEQ,    HBURST_INCR,   1'b1, 16'h0001, 16'h0001, 4'd0, 1'b0);
        add("oi_release",  16'hFFFE, 16'h0000, HTRANS_SEQ,    HBURST_INCR,   1'b1, 16'h0002, 16'h0001, 4'd1, 1'b0);
        // Sole requester re-granted; no request clears; pointer survives the empty cycle.
        add("sole_again",  16'h0002, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0002, 16'h0002, 4'd1, 1'b0);
        add("no_req",      16'h0000, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0000, 16'h0002, 4'd0, 1'b0);
        add("ptr_kept",    16'h0003, 16'h0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 16'h0001, 16'h0000, 4'd0, 1'b0);

        drive(16'h0000, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        repeat (2) @(posedge HCLK);
        #1;
        check_all("reset", 16'h0000, 16'h0000, 4'd0, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].req, vecs[k].lock, vecs[k].htrans, vecs[k].hburst, vecs[k].hready);
            @(posedge HCLK);
            #1;
            check_all(vecs[k].name, vecs[k].exp_addr, vecs[k].exp_data, vecs[k].exp_hm,
                      vecs[k].exp_lk);
        end

        // Locked INCR8 on port 0, reset asserted between edges during beat 3.
        drive(16'h0003, 16'h0001, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
        @(posedge HCLK);
        #1;
        check_all("i8_ns", 16'h0001, 16'h0001, 4'd0, 1'b1);
        drive(16'h0003, 16'h0001, HTRANS_SEQ, HBURST_INCR8, 1'b1);
        @(posedge HCLK);
        #1;
        check_all("i8_s1", 16'h0001, 16'h0001, 4'd0, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 16'h0000, 4'd0, 1'b0);
        @(posedge HCLK);
        @(negedge HCLK);
        drive(16'h0003, 16'h0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_all("post_rst0", 16'h0001, 16'h0000, 4'd0, 1'b0);
        @(posedge HCLK);
        #1;
        check_all("post_rst1", 16'h0002, 16'h0001, 4'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
